// File: rtl/urisc_pkg.sv
// urisc_pkg: state encoding and shared constants for the SUBLEQ sequencer
// Contents:
//   state_t      sequencer states S_IDLE..S_HALT
//   INSTR_LEN    words per instruction (A, B, C)
//   DEF_IO_ADDR  default address decoded as the I/O port
package urisc_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FA, S_FB, S_FC, S_RA, S_RB, S_EX, S_HALT} state_t;
    localparam int INSTR_LEN = 3;
    localparam logic [7:0] DEF_IO_ADDR = 8'hFF;
endpackage

// File: rtl/urisc_ctrl.sv
// urisc_ctrl: SUBLEQ sequencer (mem[B] -= mem[A]; branch to C if result <= 0) on a sync RAM port
// Build option: define URISC_HALT_EN to stop in HALT on a taken self-branch (C == pc).
// Ports:
//   clk, reset (async, active-low), run       control; run=0 stops at an instruction boundary
//   in_port, out_port                         I/O mapped at IO_ADDR (read -> in_port, write -> out_port)
//   mem_addr, mem_re, mem_we, mem_wdata       RAM request; mem_rdata returns one cycle after mem_re
//   pc, busy, halted                          status
module urisc_ctrl
    import urisc_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter logic [AW-1:0] IO_ADDR = DEF_IO_ADDR,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [DW-1:0] in_port,
    output logic [DW-1:0] out_port,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);
    state_t        state;
    logic [AW-1:0] a, b, c, pc_nx;
    logic [DW-1:0] val_a, val_b, d;
    logic          le, halt_now;

    // Strobes and addresses are registered on entry to each state, so the read
    // issued in state X returns in the state after X; in EX mem_rdata holds mem[B].
    always_comb begin
        val_b = (b == IO_ADDR) ? '0 : mem_rdata;
        d = val_b - val_a;
        le = d[DW-1] | (d == '0);
        pc_nx = le ? c : pc + AW'(INSTR_LEN);
    end

    // The difference is only known once mem[B] arrives in EX, so write data is
    // gated by the registered write strobe instead of being registered itself.
    assign mem_wdata = mem_we ? d : '0;

`ifdef URISC_HALT_EN
    assign halt_now = le & (c == pc);
    assign halted = (state == S_HALT);
`else
    assign halt_now = 1'b0;
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            pc <= RESET_PC;
            out_port <= '0;
            mem_addr <= '0;
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            busy <= 1'b0;
            a <= '0;
            b <= '0;
            c <= '0;
            val_a <= '0;
        end else begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                S_IDLE: if (run) begin
                    state <= S_FA;
                    busy <= 1'b1;
                    mem_addr <= pc;
                    mem_re <= 1'b1;
                end
                S_FA: begin
                    state <= S_FB;
                    mem_addr <= pc + AW'(1);
                    mem_re <= 1'b1;
                end
                S_FB: begin
                    state <= S_FC;
                    a <= mem_rdata[AW-1:0];
                    mem_addr <= pc + AW'(2);
                    mem_re <= 1'b1;
                end
                S_FC: begin
                    state <= S_RA;
                    b <= mem_rdata[AW-1:0];
                    mem_addr <= a;
                    mem_re <= (a != IO_ADDR);
                end
                S_RA: begin
                    state <= S_RB;
                    c <= mem_rdata[AW-1:0];
                    mem_addr <= b;
                    mem_re <= (b != IO_ADDR);
                end
                S_RB: begin
                    state <= S_EX;
                    val_a <= (a == IO_ADDR) ? in_port : mem_rdata;
                    mem_we <= (b != IO_ADDR);
                end
                S_EX: begin
                    pc <= pc_nx;
                    if (b == IO_ADDR) out_port <= d;
                    if (halt_now) begin
                        state <= S_HALT;
                        busy <= 1'b0;
                    end else if (run) begin
                        state <= S_FA;
                        mem_addr <= pc_nx;
                        mem_re <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy <= 1'b0;
                    end
                end
                S_HALT: state <= S_HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_urisc_ctrl.sv
// tb_urisc_ctrl: scoreboard bench for urisc_ctrl with a SUBLEQ reference model and sync RAM
module tb_urisc_ctrl;
    logic       clk = 1'b1;
    logic       reset, run;
    logic [7:0] in_port, out_port, mem_addr, mem_wdata, mem_rdata, pc;
    logic       mem_re, mem_we, busy, halted;
    logic       bd_we;
    logic [7:0] bd_addr, bd_data;
    logic [7:0] ram [256];

    typedef struct {
        logic [7:0] pc, a, b, c, nxt, wa, wd, outv;
        bit         wr, halt;
    } rec_t;

    rec_t       q[$];
    rec_t       cur;
    int         ph = 0;
    int         tests = 0, fails = 0;
    logic [7:0] mm [256];
    logic [7:0] mpc = 8'h00, mout = 8'h00;
    bit         mhalt = 0;

    urisc_ctrl dut (
        .clk(clk), .reset(reset), .run(run), .in_port(in_port), .out_port(out_port),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one SUBLEQ instruction on the bench's memory image.
    task automatic step();
        rec_t       r;
        logic [7:0] p1, p2, va, vb, d;
        bit         le;
        p1 = mpc + 8'd1;
        p2 = mpc + 8'd2;
        r.pc = mpc;
        r.a = mm[mpc];
        r.b = mm[p1];
        r.c = mm[p2];
        va = (r.a == 8'hFF) ? in_port : mm[r.a];
        vb = (r.b == 8'hFF) ? 8'h00 : mm[r.b];
        d = vb - va;
        r.wr = (r.b != 8'hFF);
        r.wa = r.b;
        r.wd = d;
        if (r.wr) mm[r.b] = d;
        else mout = d;
        le = ($signed(d) <= 0);
        r.halt = 0;
`ifdef URISC_HALT_EN
        if (le && r.c == mpc) r.halt = 1;
`endif
        mpc = le ? r.c : mpc + 8'd3;
        mhalt = r.halt;
        r.nxt = mpc;
        r.outv = mout;
        q.push_back(r);
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        bd_addr = a;
        bd_data = v;
        bd_we = 1'b1;
        mm[a] = v;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        mpc = 8'h00;
        mout = 8'h00;
        mhalt = 0;
    endtask

    task automatic run_prog(input int n);
        int k = 0;
        int t;
        for (int i = 0; i < n && !mhalt; i++) begin
            step();
            k++;
        end
        if (k == 0) return;
        run = 1'b1;
        @(posedge clk);
        repeat (6 * k - 5) @(posedge clk);
        #1 run = 1'b0;
        for (t = 0; busy && t < 60; t++) begin
            @(posedge clk);
            #1;
        end
        chk("idle_reached", busy, 0);
        repeat (2) @(posedge clk);
        #1 chk("sb_drain", q.size(), 0);
        q.delete();
    endtask

    // Monitor: follows each instruction from its fetch strobe and checks the bus and status.
    always @(negedge clk) begin
        if (!reset) ph = 0;
        else begin
            chk("strobe_excl", mem_re & mem_we, 0);
            if (ph == 6) begin
                chk("pc_next", pc, cur.nxt);
                chk("out_port", out_port, cur.outv);
                chk("halted", halted, cur.halt);
                if (cur.halt) chk("halt_busy", busy, 0);
                ph = 0;
            end
            if (ph == 0) begin
                if (mem_re && busy) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_fetch: addr %0h with no instruction expected", mem_addr);
                    end else begin
                        cur = q.pop_front();
                        chk("fetch_pc", mem_addr, cur.pc);
                        ph = 1;
                    end
                end
            end else begin
                case (ph)
                    1: begin
                        chk("fb_re", mem_re, 1);
                        chk("fb_addr", mem_addr, 8'(cur.pc + 8'd1));
                    end
                    2: begin
                        chk("fc_re", mem_re, 1);
                        chk("fc_addr", mem_addr, 8'(cur.pc + 8'd2));
                    end
                    3: begin
                        chk("ra_re", mem_re, cur.a != 8'hFF);
                        if (cur.a != 8'hFF) chk("ra_addr", mem_addr, cur.a);
                    end
                    4: begin
                        chk("rb_re", mem_re, cur.b != 8'hFF);
                        if (cur.b != 8'hFF) chk("rb_addr", mem_addr, cur.b);
                    end
                    default: begin
                        chk("ex_we", mem_we, cur.wr);
                        chk("ex_re", mem_re, 0);
                        chk("ex_busy", busy, 1);
                        if (cur.wr) begin
                            chk("ex_addr", mem_addr, cur.wa);
                            chk("ex_wdata", mem_wdata, cur.wd);
                        end
                    end
                endcase
                ph++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        run = 1'b0;
        bd_we = 1'b0;
        bd_addr = 8'h00;
        bd_data = 8'h00;
        in_port = 8'h00;
        #50;
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_re", mem_re, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_out", out_port, 0);
        chk("rst_halted", halted, 0);
        #55 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_pc", pc, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_re", mem_re, 0);
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        // basic subtract, not taken
        do_reset();
        poke(0, 10); poke(1, 11); poke(2, 3); poke(10, 2); poke(11, 5);
        run_prog(1);
        // result zero and negative, both taken
        do_reset();
        poke(2, 8'h40); poke(10, 5); poke(11, 5);
        run_prog(1);
        do_reset();
        poke(10, 7); poke(11, 5);
        run_prog(1);
        // I/O read then I/O write
        do_reset();
        in_port = 8'd5;
        poke(0, 8'hFF); poke(1, 20); poke(2, 3);
        poke(3, 20); poke(4, 8'hFF); poke(5, 6); poke(20, 9);
        run_prog(2);
        // pc wrap from 0xFD
        do_reset();
        poke(0, 30); poke(1, 30); poke(2, 8'hFD);
        poke(8'hFD, 31); poke(8'hFE, 32); poke(8'hFF, 8'h77); poke(31, 1); poke(32, 5);
        run_prog(2);
        // self-loop
        do_reset();
        poke(0, 12); poke(1, 12); poke(2, 0);
        run_prog(3);
        // random programs
        do_reset();
        for (int r = 0; r < 10; r++) begin
            in_port = 8'($urandom);
            for (int j = 0; j < 4; j++) poke(8'($urandom), 8'($urandom));
            run_prog($urandom_range(1, 10));
            if (mhalt) do_reset();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
